ysyx_23060096_seq_ctrl: RTL and testbench
=========================================

YSYX_23060096_SEQ_CTRL -- requirements
Module: ysyx_23060096_seq_ctrl

Interface
REQ-001 SHALL expose: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL expose: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL expose: ifu_req  output  1  instruction fetch request, level, held until accepted.
REQ-004 SHALL expose: ifu_valid  input  1  fetch response valid; ifu_rdata is sampled when ifu_valid=1.
REQ-005 SHALL expose: ifu_rdata  input  32  fetched instruction word.
REQ-006 SHALL expose: inst  output  32  latched current instruction; drives decoder, immediate generator and register-file addresses.
REQ-007 SHALL expose: dec_regwr  input  1  decoder RegWr for the current inst.
REQ-008 SHALL expose: dec_memrd, dec_memwr  input  1 each  decoder load / store flags for the current inst.
REQ-009 SHALL expose: lsu_req  output  1  load/store request, level, held until lsu_ready.
REQ-010 SHALL expose: lsu_ready  input  1  load/store completion.
REQ-011 SHALL expose: reg_we  output  1  register-file write enable, one-cycle pulse.
REQ-012 SHALL expose: pc_we  output  1  PC update enable, one-cycle pulse.
REQ-013 SHALL expose: halted  output  1  core stopped (ebreak or bus timeout).
REQ-014 SHALL expose: bus_err  output  1  halt was caused by a timeout.
REQ-015 SHALL expose: retire_cnt  output  32  count of retired instructions.
REQ-016 SHALL expose: state  output  3  current FSM state, for debug.

Function
REQ-017 FSM states SHALL be IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to HALT with bus_err=1.
REQ-018 IDLE SHALL last exactly one cycle after reset deassertion, then go to FETCH.
REQ-019 FETCH: ifu_req=1. On ifu_valid=1, inst SHALL load ifu_rdata. The FSM SHALL go to HALT if ifu_rdata==32'h0010_0073 (ebreak), else to EXEC.
REQ-020 EXEC SHALL last one cycle. It SHALL go to MEM if dec_memrd|dec_memwr, else to WB.
REQ-021 MEM: lsu_req=1 until the cycle lsu_ready=1, then go to WB.
REQ-022 WB SHALL last one cycle with pc_we=1, reg_we=dec_regwr and retire_cnt incremented by 1. It SHALL then go to FETCH.
REQ-023 reg_we and pc_we SHALL be 0 in every state other than WB.
REQ-024 ifu_req SHALL be 1 only in FETCH; lsu_req SHALL be 1 only in MEM.
REQ-025 inst SHALL hold its value outside FETCH-with-ifu_valid; ebreak SHALL also be latched into inst.
REQ-026 ifu_valid outside FETCH and lsu_ready outside MEM SHALL be ignored.
REQ-027 Minimum latency SHALL be 3 cycles per non-memory instruction (FETCH with same-cycle ifu_valid, EXEC, WB). Minimum latency SHALL be 4 cycles per load/store.
REQ-028 An 8-bit watchdog SHALL count consecutive cycles in FETCH without ifu_valid, or in MEM without lsu_ready. It SHALL clear on state change.
REQ-029 When the watchdog reaches 255, the next edge SHALL go to HALT with bus_err=1.
REQ-030 A response arriving in the same cycle the watchdog reaches 255 SHALL win: normal transition, no error.
REQ-031 HALT SHALL be sticky until rst: halted=1 and all request/enable outputs 0.
REQ-032 retire_cnt SHALL wrap from 32'hFFFF_FFFF to 0. It SHALL NOT count ebreak.

Reset
REQ-033 rst=1 SHALL force, asynchronously: state=IDLE, inst=32'h0000_0013 (nop), retire_cnt=0, watchdog=0, halted=0, bus_err=0, ifu_req=0, lsu_req=0, reg_we=0, pc_we=0.
REQ-034 Reset asserted mid-fetch or mid-MEM SHALL abandon the transaction; no reg_we/pc_we pulse SHALL follow.

Verification
REQ-035 The bench SHALL drive an addi (0x00100093) with ifu_valid on the first FETCH cycle, dec_regwr=1 -> states 1,2,4; exactly one reg_we/pc_we pulse; retire_cnt=1.
REQ-036 The bench SHALL drive a load with dec_memrd=1 and lsu_ready after 3 MEM cycles -> lsu_req high 4 cycles; WB reached; retire_cnt increments once.
REQ-037 The bench SHALL drive ifu_rdata=0x00100073 -> HALT next cycle; halted=1, bus_err=0; no further ifu_req; retire_cnt unchanged.
REQ-038 The bench SHALL hold ifu_valid=0 in FETCH -> HALT after 256 FETCH cycles with bus_err=1. With ifu_valid on the 256th cycle, the FSM SHALL go to EXEC and bus_err SHALL stay 0.
REQ-039 The bench SHALL preload retire_cnt near wrap via 2 instructions from 32'hFFFF_FFFF-1 (force) -> value SHALL read 0.
REQ-040 The bench SHALL assert rst during MEM -> outputs take their REQ-033 values immediately; after release, IDLE then FETCH.

Source files
------------

// File: rtl/ysyx_23060096_seq_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_23060096_seq_ctrl
// Multi-cycle sequencing controller for a simple RV core. Walks every
// instruction through FETCH -> EXEC -> (MEM) -> WB, latches the fetched word,
// generates the single-cycle register-file and PC write strobes, counts
// retired instructions and stops the core on ebreak or on a stalled bus.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   ifu_req           fetch request, high for the whole FETCH state
//   ifu_valid/rdata   fetch response; rdata captured when valid in FETCH
//   inst              latched current instruction (nop after reset)
//   dec_regwr         decoder RegWr for inst, gates reg_we in WB
//   dec_memrd/memwr   decoder load/store flags, select the MEM path
//   lsu_req/ready     load/store handshake, request held until ready
//   reg_we, pc_we     one-cycle write strobes, only in WB
//   halted, bus_err   core stopped; bus_err marks a timeout / illegal state
//   retire_cnt        retired-instruction counter (wraps, ebreak excluded)
//   state             current FSM state for debug
// ----------------------------------------------------------------------------
module ysyx_23060096_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  input  logic        ifu_valid,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst,
  input  logic        dec_regwr,
  input  logic        dec_memrd,
  input  logic        dec_memwr,
  output logic        lsu_req,
  input  logic        lsu_ready,
  output logic        reg_we,
  output logic        pc_we,
  output logic        halted,
  output logic        bus_err,
  output logic [31:0] retire_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    HALT  = 3'd5
  } state_e;

  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [7:0]  WDOG_MAX = 8'hFF;

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] retire_q, retire_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        bus_err_q, bus_err_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch; blocking
  // assignments are used because this is pure combinational logic.
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    retire_d  = retire_q;
    bus_err_d = bus_err_q;
    ifu_req   = 1'b0;
    lsu_req   = 1'b0;
    reg_we    = 1'b0;
    pc_we     = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        ifu_req = 1'b1;
        // A response in the same cycle the watchdog saturates still wins.
        if (ifu_valid) begin
          inst_d  = ifu_rdata;
          state_d = (ifu_rdata == EBREAK) ? HALT : EXEC;
        end else if (wdog_q == WDOG_MAX) begin
          state_d   = HALT;
          bus_err_d = 1'b1;
        end
      end

      EXEC: state_d = (dec_memrd || dec_memwr) ? MEM : WB;

      MEM: begin
        lsu_req = 1'b1;
        if (lsu_ready) begin
          state_d = WB;
        end else if (wdog_q == WDOG_MAX) begin
          state_d   = HALT;
          bus_err_d = 1'b1;
        end
      end

      WB: begin
        pc_we    = 1'b1;
        reg_we   = dec_regwr;
        retire_d = retire_q + 32'd1;
        state_d  = FETCH;
      end

      HALT: ;

      // Unused encodings 6-7: treat as a fault and stop.
      default: begin
        state_d   = HALT;
        bus_err_d = 1'b1;
      end
    endcase

    // Watchdog counts only while waiting in FETCH/MEM and clears whenever
    // the state changes.
    if ((state_d == state_q) && ((state_q == FETCH) || (state_q == MEM)))
      wdog_d = wdog_q + 8'd1;
    else
      wdog_d = 8'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      inst_q    <= NOP;
      retire_q  <= 32'd0;
      wdog_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      retire_q  <= retire_d;
      wdog_q    <= wdog_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign inst       = inst_q;
  assign retire_cnt = retire_q;
  assign bus_err    = bus_err_q;
  assign halted     = (state_q == HALT);
  assign state      = state_q;

endmodule

// File: tb/tb_ysyx_23060096_seq_ctrl.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for ysyx_23060096_seq_ctrl. Inputs are driven
// just after the falling edge and outputs sampled 1 ns later, well away from
// the rising edge where the FSM updates.
// ----------------------------------------------------------------------------
module tb_ysyx_23060096_seq_ctrl;

  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] LW     = 32'h0000_2083;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req;
  logic        ifu_valid;
  logic [31:0] ifu_rdata;
  logic [31:0] inst;
  logic        dec_regwr;
  logic        dec_memrd;
  logic        dec_memwr;
  logic        lsu_req;
  logic        lsu_ready;
  logic        reg_we;
  logic        pc_we;
  logic        halted;
  logic        bus_err;
  logic [31:0] retire_cnt;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_23060096_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_req    (ifu_req),
    .ifu_valid  (ifu_valid),
    .ifu_rdata  (ifu_rdata),
    .inst       (inst),
    .dec_regwr  (dec_regwr),
    .dec_memrd  (dec_memrd),
    .dec_memwr  (dec_memwr),
    .lsu_req    (lsu_req),
    .lsu_ready  (lsu_ready),
    .reg_we     (reg_we),
    .pc_we      (pc_we),
    .halted     (halted),
    .bus_err    (bus_err),
    .retire_cnt (retire_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge; outputs are then stable for sampling.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifu_valid = 1'b0;
    ifu_rdata = 32'h0;
    dec_regwr = 1'b0;
    dec_memrd = 1'b0;
    dec_memwr = 1'b0;
    lsu_ready = 1'b0;
  endtask

  // Reset, released on a falling edge: the FSM sits in IDLE until the next
  // rising edge.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step(); #1;
    n_checks++;
    if (state !== 3'd0 || inst !== NOP || retire_cnt !== 32'd0 || halted !== 1'b0 ||
        bus_err !== 1'b0 || ifu_req !== 1'b0 || lsu_req !== 1'b0 || reg_we !== 1'b0 || pc_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d inst=%h ret=%0d hlt=%b err=%b ifu=%b lsu=%b rwe=%b pwe=%b, want 0/00000013/0/0...",
               state, inst, retire_cnt, halted, bus_err, ifu_req, lsu_req, reg_we, pc_we);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL idle_after_release: state=%0d want 0", state); end
    step(); #1;
    n_checks++;
    if (state !== 3'd1 || ifu_req !== 1'b1) begin
      n_fail++; $display("FAIL fetch_after_idle: state=%0d ifu_req=%b want 1/1", state, ifu_req);
    end
  endtask

  // Entered in the first FETCH cycle.
  task automatic test_addi();
    int we_pulses = 0;
    int pc_pulses = 0;
    ifu_valid = 1'b1; ifu_rdata = ADDI; dec_regwr = 1'b1;
    step(); #1;
    ifu_valid = 1'b0; ifu_rdata = 32'hDEAD_BEEF;
    n_checks++;
    if (state !== 3'd2 || inst !== ADDI) begin
      n_fail++; $display("FAIL addi_exec: state=%0d inst=%h want 2/%h", state, inst, ADDI);
    end
    if (reg_we) we_pulses++;
    if (pc_we)  pc_pulses++;
    step(); #1;
    n_checks++;
    if (state !== 3'd4 || reg_we !== 1'b1 || pc_we !== 1'b1 || retire_cnt !== 32'd0) begin
      n_fail++; $display("FAIL addi_wb: state=%0d rwe=%b pwe=%b ret=%0d want 4/1/1/0", state, reg_we, pc_we, retire_cnt);
    end
    if (reg_we) we_pulses++;
    if (pc_we)  pc_pulses++;
    step(); #1;
    if (reg_we) we_pulses++;
    if (pc_we)  pc_pulses++;
    n_checks++;
    if (state !== 3'd1 || retire_cnt !== 32'd1 || inst !== ADDI) begin
      n_fail++; $display("FAIL addi_retire: state=%0d ret=%0d inst=%h want 1/1/%h", state, retire_cnt, inst, ADDI);
    end
    n_checks++;
    if (we_pulses != 1 || pc_pulses != 1) begin
      n_fail++; $display("FAIL addi_pulses: reg_we=%0d pc_we=%0d want 1/1", we_pulses, pc_pulses);
    end
  endtask

  // Entered in FETCH with retire_cnt == 1.
  task automatic test_load();
    int req_cycles = 0;
    ifu_valid = 1'b1; ifu_rdata = LW; dec_regwr = 1'b1; dec_memrd = 1'b1;
    lsu_ready = 1'b1;                    // ignored outside MEM
    step(); #1;
    ifu_valid = 1'b0;
    n_checks++;
    if (state !== 3'd2 || lsu_req !== 1'b0) begin
      n_fail++; $display("FAIL load_exec: state=%0d lsu_req=%b want 2/0", state, lsu_req);
    end
    lsu_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) lsu_ready = 1'b1;
      #1;
      if (lsu_req && state == 3'd3) req_cycles++;
      step();
    end
    lsu_ready = 1'b0;
    #1;
    n_checks++;
    if (req_cycles != 4) begin n_fail++; $display("FAIL load_lsu_req_cycles: got %0d want 4", req_cycles); end
    n_checks++;
    if (state !== 3'd4 || reg_we !== 1'b1 || lsu_req !== 1'b0) begin
      n_fail++; $display("FAIL load_wb: state=%0d rwe=%b lsu_req=%b want 4/1/0", state, reg_we, lsu_req);
    end
    step(); #1;
    dec_memrd = 1'b0;
    n_checks++;
    if (state !== 3'd1 || retire_cnt !== 32'd2) begin
      n_fail++; $display("FAIL load_retire: state=%0d ret=%0d want 1/2", state, retire_cnt);
    end
  endtask

  // Entered in FETCH with retire_cnt == 2.
  task automatic test_ebreak();
    int bad = 0;
    ifu_valid = 1'b1; ifu_rdata = EBREAK;
    step(); #1;
    n_checks++;
    if (state !== 3'd5 || halted !== 1'b1 || bus_err !== 1'b0 || inst !== EBREAK || retire_cnt !== 32'd2) begin
      n_fail++; $display("FAIL ebreak_halt: state=%0d hlt=%b err=%b inst=%h ret=%0d want 5/1/0/%h/2",
                         state, halted, bus_err, inst, retire_cnt, EBREAK);
    end
    ifu_rdata = ADDI; lsu_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      if (state !== 3'd5 || ifu_req || lsu_req || reg_we || pc_we || !halted || retire_cnt !== 32'd2) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL halt_sticky: %0d bad cycles want 0", bad); end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int fetch_cycles = 0;
    do_reset();
    step();                              // first FETCH cycle
    for (int i = 0; i < 300; i++) begin
      #1;
      if (state != 3'd1) break;
      fetch_cycles++;
      step();
    end
    n_checks++;
    if (fetch_cycles != 256) begin n_fail++; $display("FAIL timeout_fetch_cycles: got %0d want 256", fetch_cycles); end
    n_checks++;
    if (state !== 3'd5 || halted !== 1'b1 || bus_err !== 1'b1 || ifu_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_halt: state=%0d hlt=%b err=%b ifu_req=%b want 5/1/1/0", state, halted, bus_err, ifu_req);
    end
  endtask

  task automatic test_timeout_win();
    do_reset();
    step();                              // FETCH cycle 1
    repeat (255) step();                 // FETCH cycle 256
    #1;
    n_checks++;
    if (state !== 3'd1) begin n_fail++; $display("FAIL win_still_fetch: state=%0d want 1", state); end
    ifu_valid = 1'b1; ifu_rdata = ADDI; dec_regwr = 1'b0;
    step(); #1;
    ifu_valid = 1'b0;
    n_checks++;
    if (state !== 3'd2 || bus_err !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL win_exec: state=%0d err=%b hlt=%b want 2/0/0", state, bus_err, halted);
    end
    step(); #1;
    n_checks++;
    if (state !== 3'd4 || reg_we !== 1'b0 || pc_we !== 1'b1) begin
      n_fail++; $display("FAIL win_wb_noregwr: state=%0d rwe=%b pwe=%b want 4/0/1", state, reg_we, pc_we);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step();                              // FETCH, waiting
    force dut.retire_q = 32'hFFFF_FFFE;
    step();
    release dut.retire_q;
    #1;
    for (int n = 0; n < 2; n++) begin
      ifu_valid = 1'b1; ifu_rdata = ADDI; dec_regwr = 1'b1;
      step();
      ifu_valid = 1'b0;
      step(); step(); #1;
      n_checks++;
      if (n == 0 && retire_cnt !== 32'hFFFF_FFFF) begin
        n_fail++; $display("FAIL wrap_first: ret=%h want ffffffff", retire_cnt);
      end else if (n == 1 && retire_cnt !== 32'h0) begin
        n_fail++; $display("FAIL wrap_second: ret=%h want 00000000", retire_cnt);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_mem();
    int pulses = 0;
    do_reset();
    step();
    ifu_valid = 1'b1; ifu_rdata = LW; dec_regwr = 1'b1; dec_memwr = 1'b1;
    step();
    ifu_valid = 1'b0;
    step(); step(); #1;                  // second MEM cycle
    n_checks++;
    if (state !== 3'd3 || lsu_req !== 1'b1) begin
      n_fail++; $display("FAIL mem_before_reset: state=%0d lsu_req=%b want 3/1", state, lsu_req);
    end
    #1 rst = 1'b1; lsu_ready = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd0 || inst !== NOP || retire_cnt !== 32'd0 || halted !== 1'b0 || bus_err !== 1'b0 ||
        ifu_req !== 1'b0 || lsu_req !== 1'b0 || reg_we !== 1'b0 || pc_we !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_mem: state=%0d inst=%h ret=%0d lsu_req=%b rwe=%b pwe=%b want 0/00000013/0/0/0/0",
                         state, inst, retire_cnt, lsu_req, reg_we, pc_we);
    end
    step(); step();
    rst = 1'b0; lsu_ready = 1'b0;
    #1;
    if (reg_we || pc_we) pulses++;
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL post_reset_idle: state=%0d want 0", state); end
    step(); #1;
    if (reg_we || pc_we) pulses++;
    n_checks++;
    if (state !== 3'd1 || pulses != 0) begin
      n_fail++; $display("FAIL post_reset_fetch: state=%0d pulses=%0d want 1/0", state, pulses);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load();
    test_ebreak();
    test_timeout();
    test_timeout_win();
    test_wrap();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
